// File: rtl/aes_inv_key_expand_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : aes_inv_key_expand_pkg
//  Purpose : Shared definitions for the decrypt-side AES-128 key schedule.
//            Holds the controller state encoding, the round-count constant,
//            the round-constant table and the byte S-box function.
//  Ports   : none (package)
//  Revision: 1.0 - initial release
// ============================================================================
package aes_inv_key_expand_pkg;

    localparam int NR_AES128 = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_READY  = 2'd2
    } state_t;

    // Round constant for forward step index 0..9; other indices return 0.
    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd0:    r = 8'h01;
            4'd1:    r = 8'h02;
            4'd2:    r = 8'h04;
            4'd3:    r = 8'h08;
            4'd4:    r = 8'h10;
            4'd5:    r = 8'h20;
            4'd6:    r = 8'h40;
            4'd7:    r = 8'h80;
            4'd8:    r = 8'h1b;
            4'd9:    r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = gf_xtime(t);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (x^2 * x^4 * ... * x^128); maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = x;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    // Forward S-box: field inverse followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_key_expand_sub_word.sv
`default_nettype none
// ============================================================================
//  Module  : aes_inv_key_expand_sub_word
//  Purpose : SubWord(RotWord(w)) - rotates a 32-bit word left by one byte and
//            passes each byte through the AES S-box. Purely combinational.
//  Ports   : word_in  [31:0] in  - word to transform
//            word_out [31:0] out - S-box substituted, rotated word
//  Revision: 1.0 - initial release
// ============================================================================
module aes_inv_key_expand_sub_word
    import aes_inv_key_expand_pkg::*;
(
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    logic [31:0] rot;

    assign rot = {word_in[23:0], word_in[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        assign word_out[8*b +: 8] = sbox(rot[8*b +: 8]);
    end

endmodule
`default_nettype wire

// File: rtl/aes_inv_key_expand.sv
`default_nettype none
// ============================================================================
//  Module  : aes_inv_key_expand
//  Purpose : Decrypt-side AES-128 key schedule. A key load runs the forward
//            expansion for NR cycles to reach the last round key, which is
//            also kept for rewind. Each accepted 'next' then steps one round
//            backward with the inverse expansion.
//  Ports   : clk       in       rising-edge clock
//            rst       in       asynchronous active-low reset
//            kld       in       load key / restart expansion
//            key       in  128  cipher key, word0 = key[127:96]
//            next      in       step back one round (READY, rk_round != 0)
//            rew       in       rewind to the last round key (READY)
//            busy      out      forward expansion in progress
//            rk_valid  out      rk holds a valid round key
//            rk_round  out  4   round index of rk
//            rk        out 128  current round key, word0 = rk[127:96]
//  Revision: 1.0 - initial release
// ============================================================================
module aes_inv_key_expand
    import aes_inv_key_expand_pkg::*;
#(
    parameter int NR = NR_AES128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         kld,
    input  logic [127:0] key,
    input  logic         next,
    input  logic         rew,
    output logic         busy,
    output logic         rk_valid,
    output logic [3:0]   rk_round,
    output logic [127:0] rk
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);
    localparam logic [3:0] LAST_STEP  = 4'(NR - 1);

    state_t       state;
    logic [127:0] last_key;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  sub_in, sub_out;
    logic [3:0]   rc_idx;
    logic [31:0]  rc_word;
    logic [127:0] fwd_key, rev_key;
    logic         expanding;

    assign {w0, w1, w2, w3} = rk;
    assign expanding = (state == ST_EXPAND);

    // The single SubWord unit sees w3 going forward and the recovered
    // previous-round w3 (w3^w2) going backward.
    assign sub_in  = expanding ? w3 : (w3 ^ w2);
    // Stepping back from round r reuses the constant of forward step r-1.
    assign rc_idx  = expanding ? rk_round : (rk_round - 4'd1);
    assign rc_word = {rcon(rc_idx), 24'h0};

    aes_inv_key_expand_sub_word u_sub_word (
        .word_in  (sub_in),
        .word_out (sub_out)
    );

    logic [31:0] f0, f1, f2, f3;
    assign f0 = w0 ^ sub_out ^ rc_word;
    assign f1 = w1 ^ f0;
    assign f2 = w2 ^ f1;
    assign f3 = w3 ^ f2;
    assign fwd_key = {f0, f1, f2, f3};

    assign rev_key = {w0 ^ sub_out ^ rc_word, w1 ^ w0, w2 ^ w1, w3 ^ w2};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            rk       <= '0;
            rk_round <= '0;
            rk_valid <= 1'b0;
            busy     <= 1'b0;
            last_key <= '0;
        end else if (kld) begin
            // Load wins over everything and aborts any work in progress.
            state    <= ST_EXPAND;
            rk       <= key;
            rk_round <= '0;
            rk_valid <= 1'b0;
            busy     <= 1'b1;
        end else begin
            case (state)
                ST_EXPAND: begin
                    rk       <= fwd_key;
                    rk_round <= rk_round + 4'd1;
                    if (rk_round == LAST_STEP) begin
                        last_key <= fwd_key;
                        busy     <= 1'b0;
                        rk_valid <= 1'b1;
                        state    <= ST_READY;
                    end
                end
                ST_READY: begin
                    if (rew) begin
                        rk       <= last_key;
                        rk_round <= LAST_ROUND;
                    end else if (next && (rk_round != 4'd0)) begin
                        rk       <= rev_key;
                        rk_round <= rk_round - 4'd1;
                    end
                end
                default: begin
                    // IDLE: wait for a key load.
                end
            endcase
        end
    end

endmodule
`default_nettype wire
